// File: rtl/piano_keyboard_renderer_pkg.sv
// piano_keyboard_renderer_pkg: colours, scan states and note lookups
// shared by the renderer top and piano_key_mapper.
package piano_keyboard_renderer_pkg;

  localparam logic [2:0] COLOR_WHITE = 3'b111;
  localparam logic [2:0] COLOR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEY,
    S_TAIL
  } scan_state_t;

  function automatic logic [3:0] noteOf(input logic [2:0] w);
    case (w)
      3'd0:    return 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd4;
      3'd3:    return 4'd5;
      3'd4:    return 4'd7;
      3'd5:    return 4'd9;
      3'd6:    return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  // White keys with a sharp on their right-hand side: C D F G A.
  function automatic logic sharpOf(input logic [2:0] w);
    case (w)
      3'd0, 3'd1, 3'd3, 3'd4, 3'd5: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/piano_keyboard_renderer_if.sv
// piano_keyboard_renderer_if: scan position in, pixel colour out.
// master = scan generator / VGA side, slave = renderer.
interface piano_keyboard_renderer_if;
  logic [9:0] iCurrentCol;
  logic [9:0] iCurrentRow;
  logic       iPixelValid;
  logic       iFrameStart;
  logic       oR;
  logic       oG;
  logic       oB;
  logic       oPixelValid;

  modport master (
    output iCurrentCol, iCurrentRow,
    output iPixelValid, iFrameStart,
    input  oR, oG, oB, oPixelValid
  );

  modport slave (
    input  iCurrentCol, iCurrentRow,
    input  iPixelValid, iFrameStart,
    output oR, oG, oB, oPixelValid
  );
endinterface

// File: rtl/piano_keyboard_renderer_key_mapper.sv
// piano_key_mapper: maps a position inside the keyboard
// (white index, octave, offset, upper band) to {isBlack, keyIdx}.
module piano_key_mapper
  import piano_keyboard_renderer_pkg::*;
#(
  parameter int WHITE_W = 40,
  parameter int BLACK_W = 24,
  parameter int OFFW    = 6,
  parameter int OW      = 1,
  parameter int KW      = 5
) (
  input  logic [2:0]      w,
  input  logic [OW-1:0]   oct,
  input  logic [OFFW-1:0] offset,
  input  logic            upper,
  output logic            isBlack,
  output logic [KW-1:0]   keyIdx
);

  localparam logic [OFFW-1:0] R_EDGE =
    OFFW'(WHITE_W - BLACK_W / 2);
  localparam logic [OFFW-1:0] L_EDGE =
    OFFW'(BLACK_W / 2);

  logic [2:0]  wPrev;
  logic        right;
  logic        left;
  logic [3:0]  note;
  logic [15:0] base;

  assign wPrev = w - 3'd1;
  assign right = upper && sharpOf(w)
              && offset >= R_EDGE;
  assign left  = upper && w != 3'd0
              && sharpOf(wPrev)
              && offset < L_EDGE;

  always_comb begin
    isBlack = 1'b0;
    note    = noteOf(w);
    unique case (1'b1)
      right: begin
        isBlack = 1'b1;
        note    = noteOf(w) + 4'd1;
      end
      left: begin
        isBlack = 1'b1;
        note    = noteOf(wPrev) + 4'd1;
      end
      default: ;
    endcase
  end

  assign base   = 16'(oct) * 16'd12;
  assign keyIdx = KW'(base + 16'(note));

endmodule

// File: rtl/piano_keyboard_renderer.sv
// piano_keyboard_renderer: 2-stage keyboard pixel generator.
// Optional PIANO_OUTLINE_EN: 1-px black separators between white keys.
module piano_keyboard_renderer
  import piano_keyboard_renderer_pkg::*;
#(
  parameter int         NUM_OCTAVES = 2,
  parameter int         X0          = 40,
  parameter int         Y0          = 100,
  parameter int         WHITE_W     = 40,
  parameter int         WHITE_H     = 280,
  parameter int         BLACK_W     = 24,
  parameter int         BLACK_H     = 170,
  parameter logic [2:0] BG_COLOR    = 3'b011,
  parameter logic [2:0] PRESS_COLOR = 3'b100
) (
  input logic                     Clock,
  input logic                     Reset,
  input logic [12*NUM_OCTAVES-1:0] iKeysPressed,
  piano_keyboard_renderer_if.slave pix
);

  localparam int OFFW = $clog2(WHITE_W);
  localparam int OW   =
    (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1;
  localparam int KW   = $clog2(12 * NUM_OCTAVES);

  localparam logic [9:0] COL_X0  = 10'(X0);
  localparam logic [9:0] ROW_TOP = 10'(Y0);
  localparam logic [9:0] ROW_BOT = 10'(Y0 + WHITE_H);
  localparam logic [9:0] ROW_BLK = 10'(Y0 + BLACK_H);
  localparam logic [OFFW-1:0] OFF_LAST = OFFW'(WHITE_W - 1);
  localparam logic [OW-1:0]   OCT_LAST = OW'(NUM_OCTAVES - 1);

  scan_state_t     state, stateNext;
  logic [OFFW-1:0] off, offNext, curOff;
  logic [2:0]      w, wNext, curW;
  logic [OW-1:0]   oct, octNext, curOct;
  logic            inKey, startHit, upper;

  logic [12*NUM_OCTAVES-1:0] mask;

  logic          isBlack, sepNow;
  logic [KW-1:0] keyIdx;

  logic          vld1, key1, black1, sep1;
  logic [KW-1:0] idx1;
  logic [2:0]    colour, rgb;
  logic          vld2;

  assign startHit = pix.iPixelValid
                 && pix.iCurrentCol == COL_X0
                 && pix.iCurrentRow >= ROW_TOP
                 && pix.iCurrentRow < ROW_BOT;
  assign upper = pix.iCurrentRow < ROW_BLK;

  // cur* is the position of the pixel on the input this cycle.
  always_comb begin
    stateNext = state;
    offNext   = off;
    wNext     = w;
    octNext   = oct;
    inKey     = 1'b0;
    curOff    = off;
    curW      = w;
    curOct    = oct;
    unique case (state)
      S_IDLE: if (startHit) begin
        inKey  = 1'b1;
        curOff = '0;
        curW   = '0;
        curOct = '0;
      end
      S_KEY:
        if (pix.iPixelValid) inKey = 1'b1;
        else stateNext = S_IDLE;
      S_TAIL:
        if (!pix.iPixelValid) stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
    if (inKey) begin
      stateNext = S_KEY;
      offNext   = curOff + OFFW'(1);
      wNext     = curW;
      octNext   = curOct;
      if (curOff == OFF_LAST) begin
        offNext = '0;
        if (curW == 3'd6) begin
          wNext   = '0;
          octNext = curOct + OW'(1);
          if (curOct == OCT_LAST) stateNext = S_TAIL;
        end else begin
          wNext = curW + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      off   <= '0;
      w     <= '0;
      oct   <= '0;
      mask  <= '0;
    end else begin
      state <= stateNext;
      off   <= offNext;
      w     <= wNext;
      oct   <= octNext;
      if (pix.iFrameStart) mask <= iKeysPressed;
    end
  end

  piano_key_mapper #(
    .WHITE_W (WHITE_W),
    .BLACK_W (BLACK_W),
    .OFFW    (OFFW),
    .OW      (OW),
    .KW      (KW)
  ) u_mapper (
    .w       (curW),
    .oct     (curOct),
    .offset  (curOff),
    .upper   (upper),
    .isBlack (isBlack),
    .keyIdx  (keyIdx)
  );

`ifdef PIANO_OUTLINE_EN
  assign sepNow = !isBlack && curOff == '0
               && (curW != 3'd0 || curOct != '0);
`else
  assign sepNow = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld1   <= 1'b0;
      key1   <= 1'b0;
      black1 <= 1'b0;
      sep1   <= 1'b0;
      idx1   <= '0;
    end else begin
      vld1   <= pix.iPixelValid;
      key1   <= inKey;
      black1 <= isBlack;
      sep1   <= sepNow;
      idx1   <= keyIdx;
    end
  end

  always_comb begin
    colour = BG_COLOR;
    if (!key1)           colour = BG_COLOR;
    else if (sep1)       colour = COLOR_BLACK;
    else if (mask[idx1]) colour = PRESS_COLOR;
    else if (black1)     colour = COLOR_BLACK;
    else                 colour = COLOR_WHITE;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rgb  <= BG_COLOR;
      vld2 <= 1'b0;
    end else begin
      rgb  <= colour;
      vld2 <= vld1;
    end
  end

  assign pix.oR          = rgb[2];
  assign pix.oG          = rgb[1];
  assign pix.oB          = rgb[0];
  assign pix.oPixelValid = vld2;

endmodule
